// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and arbiter state encoding for the cache/memory subsystem.
//   BLK_ADDR_W : block address width (byte address minus 4 offset bits)
//   BLK_W      : block data width
//   arb_state_t: mem_arbiter FSM states
package mem_pkg;
  localparam int BLK_ADDR_W = 28;
  localparam int BLK_W = 128;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_DONE_I,
    ARB_DONE_D
  } arb_state_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of D grants made while I was waiting.
//   CLK, RESET   : clock, synchronous active-high reset
//   inc_i        : D granted while I pending
//   clr_i        : D granted with no I pending, or I granted (clr wins over inc)
//   at_limit_o   : count has reached LIMIT, I must win the next arbitration
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  logic [2:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 3'd0 : (inc_i && cnt_q != 3'd7) ? cnt_q + 3'd1 : cnt_q;
  always_ff @(posedge CLK) cnt_q <= RESET ? 3'd0 : cnt_d;
  assign at_limit_o = cnt_q >= 3'(LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between I-cache (read) and D-cache (read/write).
//   CLK, RESET                 : clock, synchronous active-high reset
//   I_MEM_READ, I_BLOCK_ADDR   : I-cache block read request
//   I_READ_DATA, I_BUSYWAIT    : block returned to I-cache, stall
//   D_MEM_READ/WRITE, D_BLOCK_ADDR, D_WRITE_DATA : D-cache request
//   D_READ_DATA, D_BUSYWAIT    : block returned to D-cache, stall
//   MEM_*                      : single latched request towards memory and its response
// D has priority; after STARVE_LIMIT consecutive D grants with I waiting, I wins.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BLK_ADDR_W = mem_pkg::BLK_ADDR_W,
  parameter int BLK_W = mem_pkg::BLK_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_MEM_READ,
  input  logic [BLK_ADDR_W-1:0] I_BLOCK_ADDR,
  output logic [BLK_W-1:0]      I_READ_DATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_MEM_READ,
  input  logic                  D_MEM_WRITE,
  input  logic [BLK_ADDR_W-1:0] D_BLOCK_ADDR,
  input  logic [BLK_W-1:0]      D_WRITE_DATA,
  output logic [BLK_W-1:0]      D_READ_DATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [BLK_ADDR_W-1:0] MEM_BLOCK_ADDR,
  output logic [BLK_W-1:0]      MEM_WRITE_DATA,
  input  logic [BLK_W-1:0]      MEM_READ_DATA,
  input  logic                  MEM_BUSYWAIT
);
  arb_state_t state_q, state_d;
  logic seen_busy_q, seen_busy_d, wr_q, wr_d;
  logic [BLK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLK_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic d_req, i_req, serve, done, grant_d, grant_i, starved;
  assign d_req = D_MEM_READ | D_MEM_WRITE;
  assign i_req = I_MEM_READ;
  assign serve = state_q == ARB_SERVE_I || state_q == ARB_SERVE_D;
  // completion needs a busy phase first, so a memory that never raises busy stalls here
  assign done = serve && seen_busy_q && !MEM_BUSYWAIT;
  assign grant_d = state_q == ARB_IDLE && d_req && (!i_req || !starved);
  assign grant_i = state_q == ARB_IDLE && i_req && !grant_d;
  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK       (CLK),
    .RESET     (RESET),
    .inc_i     (grant_d && i_req),
    .clr_i     ((grant_d && !i_req) || grant_i),
    .at_limit_o(starved)
  );
  always_comb begin
    state_d = state_q;
    if (grant_d) state_d = ARB_SERVE_D;
    else if (grant_i) state_d = ARB_SERVE_I;
    else if (done) state_d = state_q == ARB_SERVE_I ? ARB_DONE_I : ARB_DONE_D;
    else if (state_q == ARB_DONE_I || state_q == ARB_DONE_D) state_d = ARB_IDLE;
    MEM_READ = serve && !wr_q;
    MEM_WRITE = serve && wr_q;
    I_BUSYWAIT = i_req && state_q != ARB_DONE_I;
    D_BUSYWAIT = d_req && state_q != ARB_DONE_D;
  end
  always_comb begin
    seen_busy_d = serve ? (seen_busy_q || MEM_BUSYWAIT) && !done : seen_busy_q;
    wr_d = grant_d ? D_MEM_WRITE : grant_i ? 1'b0 : wr_q;
    addr_d = grant_d ? D_BLOCK_ADDR : grant_i ? I_BLOCK_ADDR : addr_q;
    wdata_d = grant_d ? D_WRITE_DATA : wdata_q;
    i_rdata_d = (done && !wr_q && state_q == ARB_SERVE_I) ? MEM_READ_DATA : i_rdata_q;
    d_rdata_d = (done && !wr_q && state_q == ARB_SERVE_D) ? MEM_READ_DATA : d_rdata_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ARB_IDLE;
      seen_busy_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      seen_busy_q <= seen_busy_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign MEM_BLOCK_ADDR = addr_q;
  assign MEM_WRITE_DATA = wdata_q;
  assign I_READ_DATA = i_rdata_q;
  assign D_READ_DATA = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural busy-wait memory.
module tb_mem_arbiter;
  logic CLK = 0, RESET = 1;
  logic I_MEM_READ = 0, D_MEM_READ = 0, D_MEM_WRITE = 0, MEM_BUSYWAIT = 0;
  logic [27:0] I_BLOCK_ADDR = '0, D_BLOCK_ADDR = '0, MEM_BLOCK_ADDR;
  logic [127:0] D_WRITE_DATA = '0, MEM_READ_DATA = '0;
  logic [127:0] I_READ_DATA, D_READ_DATA, MEM_WRITE_DATA;
  logic I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [127:0] mem_rdata = '0;
  int mem_lat = 5;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic wr; logic [27:0] addr; logic [127:0] wdata; int dur;} mem_exp_t;
  mem_exp_t exp_mem[$];
  logic [127:0] exp_i[$], exp_d[$];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_MEM_READ(I_MEM_READ), .I_BLOCK_ADDR(I_BLOCK_ADDR), .I_READ_DATA(I_READ_DATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_MEM_READ(D_MEM_READ), .D_MEM_WRITE(D_MEM_WRITE), .D_BLOCK_ADDR(D_BLOCK_ADDR),
    .D_WRITE_DATA(D_WRITE_DATA), .D_READ_DATA(D_READ_DATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_mem(input logic wr, input logic [27:0] a, input logic [127:0] d, input int dur);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.dur = dur;
    exp_mem.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (is_d ? ((D_MEM_READ || D_MEM_WRITE) && !D_BUSYWAIT) : (I_MEM_READ && !I_BUSYWAIT)) return;
    end
    chk({name, "_timeout"}, 128'd1, 128'd0);
  endtask

  task automatic wait_strobe();
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) return;
    end
    chk("strobe_timeout", 128'd1, 128'd0);
  endtask

  // memory: raises busy for mem_lat negedges once it sees a strobe, then presents data
  initial begin
    int busy_cnt = 0;
    bit mem_done = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        MEM_BUSYWAIT = 0; busy_cnt = 0; mem_done = 0;
      end else if (MEM_BUSYWAIT) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          MEM_BUSYWAIT = 0; MEM_READ_DATA = mem_rdata; mem_done = 1;
        end
      end else if (MEM_READ || MEM_WRITE) begin
        if (!mem_done) begin
          MEM_BUSYWAIT = 1; busy_cnt = mem_lat;
        end
      end else mem_done = 0;
    end
  end

  // monitor: checks each memory transaction and each returned block against the queues
  initial begin
    mem_exp_t cur;
    bit prev_s = 0, s, addr_ok = 1;
    int dur = 0;
    cur.wr = 0; cur.addr = '0; cur.wdata = '0; cur.dur = 0;
    forever begin
      @(negedge CLK);
      s = MEM_READ || MEM_WRITE;
      if (s && !prev_s) begin
        if (exp_mem.size() == 0) chk("unexpected_strobe", 128'd1, 128'd0);
        else begin
          cur = exp_mem.pop_front();
          chk("mem_op", 128'({MEM_READ, MEM_WRITE}), 128'({!cur.wr, cur.wr}));
          chk("mem_addr", 128'(MEM_BLOCK_ADDR), 128'(cur.addr));
          if (cur.wr) chk("mem_wdata", MEM_WRITE_DATA, cur.wdata);
        end
        dur = 0; addr_ok = 1;
      end
      if (s) begin
        dur++;
        if (MEM_BLOCK_ADDR !== cur.addr) addr_ok = 0;
      end
      if (!s && prev_s) begin
        chk("addr_stable", 128'(addr_ok), 128'd1);
        if (cur.dur != 0) chk("strobe_len", 128'(dur), 128'(cur.dur));
      end
      if (I_MEM_READ && !I_BUSYWAIT) begin
        if (exp_i.size() == 0) chk("unexpected_i_done", 128'd1, 128'd0);
        else chk("i_rdata", I_READ_DATA, exp_i.pop_front());
      end
      if ((D_MEM_READ || D_MEM_WRITE) && !D_BUSYWAIT) begin
        if (exp_d.size() == 0) chk("unexpected_d_done", 128'd1, 128'd0);
        else chk("d_rdata", D_READ_DATA, exp_d.pop_front());
      end
      prev_s = s;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    RESET = 0;
    @(negedge CLK);
    chk("rst_mem_read", 128'(MEM_READ), 128'd0);
    chk("rst_mem_write", 128'(MEM_WRITE), 128'd0);
    chk("rst_i_rdata", I_READ_DATA, 128'd0);
    chk("rst_d_rdata", D_READ_DATA, 128'd0);
    chk("rst_addr", 128'(MEM_BLOCK_ADDR), 128'd0);
    // D read alone
    mem_rdata = {16{8'hA5}};
    push_mem(0, 28'h10, '0, 6);
    exp_d.push_back({16{8'hA5}});
    tick();
    D_MEM_READ = 1; D_BLOCK_ADDR = 28'h10;
    wait_done(1, "t1_d");
    tick();
    D_MEM_READ = 0;
    chk("t1_i_rdata", I_READ_DATA, 128'd0);
    // I and D together: D write first, then I read
    mem_rdata = {16{8'hC3}};
    push_mem(1, 28'h30, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 6);
    push_mem(0, 28'h20, '0, 6);
    exp_d.push_back({16{8'hA5}});
    exp_i.push_back({16{8'hC3}});
    tick();
    I_MEM_READ = 1; I_BLOCK_ADDR = 28'h20;
    D_MEM_WRITE = 1; D_BLOCK_ADDR = 28'h30; D_WRITE_DATA = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    wait_done(1, "t2_d");
    chk("t2_i_busy", 128'(I_BUSYWAIT), 128'd1);
    tick();
    D_MEM_WRITE = 0;
    wait_done(0, "t2_i");
    tick();
    I_MEM_READ = 0;
    // starvation: D x4, I, D (counter cleared), I
    mem_rdata = {16{8'h77}};
    for (int k = 0; k < 4; k++) push_mem(0, 28'h60, '0, 6);
    push_mem(0, 28'h70, '0, 6);
    push_mem(0, 28'h60, '0, 6);
    push_mem(0, 28'h70, '0, 6);
    repeat (5) exp_d.push_back({16{8'h77}});
    repeat (2) exp_i.push_back({16{8'h77}});
    I_MEM_READ = 1; I_BLOCK_ADDR = 28'h70;
    D_MEM_READ = 1; D_BLOCK_ADDR = 28'h60;
    for (int k = 0; k < 4; k++) begin
      wait_done(1, "t3_d");
      chk("t3_i_busy", 128'(I_BUSYWAIT), 128'd1);
    end
    wait_done(0, "t3_i");
    wait_done(1, "t3_d5");
    tick();
    D_MEM_READ = 0;
    wait_done(0, "t3_i2");
    tick();
    I_MEM_READ = 0;
    // read and write together: write wins, D_READ_DATA unchanged
    push_mem(1, 28'h90, {4{32'hDEAD_BEEF}}, 6);
    exp_d.push_back({16{8'h77}});
    D_MEM_READ = 1; D_MEM_WRITE = 1; D_BLOCK_ADDR = 28'h90; D_WRITE_DATA = {4{32'hDEAD_BEEF}};
    wait_done(1, "t4_d");
    tick();
    D_MEM_READ = 0; D_MEM_WRITE = 0;
    // reset during SERVE_I, held request completes afterwards
    mem_rdata = {16{8'h3C}};
    push_mem(0, 28'h80, '0, 0);
    push_mem(0, 28'h80, '0, 6);
    exp_i.push_back({16{8'h3C}});
    tick();
    I_MEM_READ = 1; I_BLOCK_ADDR = 28'h80;
    wait_strobe();
    @(posedge CLK);
    #1 RESET = 1;
    tick();
    RESET = 0;
    @(negedge CLK);
    chk("t5_mem_read", 128'(MEM_READ), 128'd0);
    chk("t5_i_rdata", I_READ_DATA, 128'd0);
    chk("t5_d_rdata", D_READ_DATA, 128'd0);
    wait_done(0, "t5_i");
    tick();
    I_MEM_READ = 0;
    // address change mid-transfer is ignored
    mem_rdata = {16{8'h5E}};
    push_mem(0, 28'h40, '0, 6);
    exp_d.push_back({16{8'h5E}});
    tick();
    D_MEM_READ = 1; D_BLOCK_ADDR = 28'h40;
    wait_strobe();
    tick();
    D_BLOCK_ADDR = 28'h50;
    wait_done(1, "t6_d");
    tick();
    D_MEM_READ = 0;
    @(negedge CLK);
    chk("t6_idle_addr", 128'(MEM_BLOCK_ADDR), 128'h40);
    repeat (4) tick();
    chk("left_mem", 128'(exp_mem.size()), 128'd0);
    chk("left_i", 128'(exp_i.size()), 128'd0);
    chk("left_d", 128'(exp_d.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
